// File: rtl/param_combo_lock_if.sv
// rtl/param_combo_lock_if.sv - entry/status bundle between keypad conditioner, lock and display.
// The prog pulse exists only when COMBO_LOCK_PROG_EN is defined.
interface param_combo_lock_if #(
    parameter int DIGIT_W   = 4,
    parameter int CODE_LEN  = 4,
    parameter int MAX_TRIES = 3
);
    localparam int DC_W = $clog2(CODE_LEN + 1);
    localparam int TL_W = $clog2(MAX_TRIES + 1);

    logic               enter;
    logic [DIGIT_W-1:0] digit;
    logic               relock;
`ifdef COMBO_LOCK_PROG_EN
    logic               prog;
`endif
    logic [2:0]         state;
    logic               open;
    logic               fail;
    logic               locked_out;
    logic [DC_W-1:0]    digit_count;
    logic [TL_W-1:0]    tries_left;

    modport master (
`ifdef COMBO_LOCK_PROG_EN
        output prog,
`endif
        output enter, digit, relock,
        input  state, open, fail, locked_out, digit_count, tries_left
    );

    modport slave (
`ifdef COMBO_LOCK_PROG_EN
        input  prog,
`endif
        input  enter, digit, relock,
        output state, open, fail, locked_out, digit_count, tries_left
    );
endinterface

// File: rtl/param_combo_lock.sv
// rtl/param_combo_lock.sv - parametrised combination lock with retry limit and timed lockout.
// Define COMBO_LOCK_PROG_EN to make the code reprogrammable from the OPEN state.
module param_combo_lock #(
    parameter int                          DIGIT_W        = 4,
    parameter int                          CODE_LEN       = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] CODE           = 16'h1234,
    parameter int                          MAX_TRIES      = 3,
    parameter int                          LOCKOUT_CYCLES = 250000000
) (
    input  logic              clk,
    input  logic              rst_n,
    param_combo_lock_if.slave bus
);
    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int DC_W   = $clog2(CODE_LEN + 1);
    localparam int TL_W   = $clog2(MAX_TRIES + 1);
    localparam int CNT_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [DC_W-1:0]  LAST_IDX = DC_W'(CODE_LEN - 1);
    localparam logic [TL_W-1:0]  FULL_TL  = TL_W'(MAX_TRIES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_OPEN    = 3'd1,
        S_FAIL    = 3'd2,
`ifdef COMBO_LOCK_PROG_EN
        S_LOCKOUT = 3'd3,
        S_PROG    = 3'd4
`else
        S_LOCKOUT = 3'd3
`endif
    } state_t;

    state_t            state_q, state_d;
    logic              flag_q, flag_d;
    logic [DC_W-1:0]   dc_q, dc_d;
    logic [TL_W-1:0]   tl_q, tl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              open_q, fail_q, lo_q;
    logic [CODE_W-1:0] code_q;

`ifdef COMBO_LOCK_PROG_EN
    logic [CODE_W-1:0] code_d;
    logic [CODE_W-1:0] stage_q, stage_d;
    logic [CODE_W-1:0] stage_next;
`else
    assign code_q = CODE;
`endif

    logic [DC_W-1:0] idx;
    logic            flag_base;
    logic            attempt_bad;

    function automatic logic [DIGIT_W-1:0] code_digit(input logic [CODE_W-1:0] c,
                                                     input logic [DC_W-1:0]   pos);
        logic [DIGIT_W-1:0] d;
        d = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (pos == DC_W'(i)) d = c[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
        end
        return d;
    endfunction

    always_comb begin
        state_d = state_q;
        flag_d  = flag_q;
        dc_d    = dc_q;
        tl_d    = tl_q;
        cnt_d   = cnt_q;
`ifdef COMBO_LOCK_PROG_EN
        code_d     = code_q;
        stage_d    = stage_q;
        stage_next = CODE_W'({stage_q, bus.digit});
`endif
        // An Enter in FAIL starts a fresh attempt, so it is scored as digit 0.
        idx         = (state_q == S_FAIL) ? '0 : dc_q;
        flag_base   = (state_q == S_FAIL) ? 1'b0 : flag_q;
        attempt_bad = flag_base | (bus.digit != code_digit(code_q, idx));

        case (state_q)
            S_IDLE, S_FAIL: begin
                if (bus.relock) begin
                    state_d = S_IDLE;
                    dc_d    = '0;
                    flag_d  = 1'b0;
                end else if (bus.enter) begin
                    if (idx == LAST_IDX) begin
                        dc_d   = '0;
                        flag_d = 1'b0;
                        if (!attempt_bad) begin
                            state_d = S_OPEN;
                            tl_d    = FULL_TL;
                        end else if (tl_q <= TL_W'(1)) begin
                            state_d = S_LOCKOUT;
                            tl_d    = '0;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_FAIL;
                            tl_d    = tl_q - TL_W'(1);
                        end
                    end else begin
                        state_d = S_IDLE;
                        dc_d    = idx + DC_W'(1);
                        flag_d  = attempt_bad;
                    end
                end
            end
            S_OPEN: begin
                if (bus.relock) begin
                    state_d = S_IDLE;
`ifdef COMBO_LOCK_PROG_EN
                end else if (bus.prog) begin
                    state_d = S_PROG;
                    dc_d    = '0;
                    stage_d = '0;
`endif
                end
            end
            S_LOCKOUT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    tl_d    = FULL_TL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef COMBO_LOCK_PROG_EN
            S_PROG: begin
                // New digits collect in a staging register so an abort keeps the old code.
                if (bus.relock) begin
                    state_d = S_OPEN;
                    dc_d    = '0;
                end else if (bus.enter) begin
                    stage_d = stage_next;
                    if (dc_q == LAST_IDX) begin
                        code_d  = stage_next;
                        dc_d    = '0;
                        state_d = S_OPEN;
                    end else begin
                        dc_d = dc_q + DC_W'(1);
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                dc_d    = '0;
                flag_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            flag_q  <= 1'b0;
            dc_q    <= '0;
            tl_q    <= FULL_TL;
            cnt_q   <= '0;
            open_q  <= 1'b0;
            fail_q  <= 1'b0;
            lo_q    <= 1'b0;
`ifdef COMBO_LOCK_PROG_EN
            code_q  <= CODE;
            stage_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            dc_q    <= dc_d;
            tl_q    <= tl_d;
            cnt_q   <= cnt_d;
            open_q  <= (state_d == S_OPEN);
            fail_q  <= (state_d == S_FAIL);
            lo_q    <= (state_d == S_LOCKOUT);
`ifdef COMBO_LOCK_PROG_EN
            code_q  <= code_d;
            stage_q <= stage_d;
`endif
        end
    end

    assign bus.state       = state_q;
    assign bus.open        = open_q;
    assign bus.fail        = fail_q;
    assign bus.locked_out  = lo_q;
    assign bus.digit_count = dc_q;
    assign bus.tries_left  = tl_q;
endmodule

// File: tb/tb_param_combo_lock.sv
// tb/tb_param_combo_lock.sv - randomized self-checking bench for param_combo_lock against a queue-based model.
module tb_param_combo_lock;
    localparam int          DIGIT_W        = 4;
    localparam int          CODE_LEN       = 4;
    localparam logic [15:0] CODE           = 16'h1234;
    localparam int          MAX_TRIES      = 3;
    localparam int          LOCKOUT_CYCLES = 10;
`ifdef COMBO_LOCK_PROG_EN
    localparam bit PROG_BUILD = 1'b1;
`else
    localparam bit PROG_BUILD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    param_combo_lock_if #(.DIGIT_W(DIGIT_W), .CODE_LEN(CODE_LEN), .MAX_TRIES(MAX_TRIES)) bus ();

    param_combo_lock #(
        .DIGIT_W(DIGIT_W), .CODE_LEN(CODE_LEN), .CODE(CODE),
        .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: 0 idle, 1 open, 2 fail, 3 lockout, 4 prog; digits held in a queue.
    int          m_state;
    int          m_seq[$];
    int          m_tries;
    int          m_lock_left;
    logic [15:0] m_code;
    logic [10:0] got, want;

    function automatic logic [15:0] pack_seq();
        logic [15:0] v;
        v = '0;
        foreach (m_seq[i]) v = {v[11:0], 4'(m_seq[i])};
        return v;
    endfunction

    function automatic int want_digit(int pos);
        logic [15:0] c;
        c = m_code;
        return int'(c[(CODE_LEN-1-pos)*4 +: 4]);
    endfunction

    function automatic logic [10:0] model_outs();
        return {3'(m_state), m_state == 1, m_state == 2, m_state == 3,
                3'(m_seq.size()), 2'(m_tries)};
    endfunction

    function automatic logic [10:0] dut_outs();
        return {bus.state, bus.open, bus.fail, bus.locked_out, bus.digit_count, bus.tries_left};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_seq.delete();
        m_tries = MAX_TRIES;
        m_lock_left = 0;
        m_code = CODE;
    endtask

    task automatic model_edge(input logic en, input logic [3:0] d, input logic rl, input logic pg);
        case (m_state)
            3: begin
                m_lock_left--;
                if (m_lock_left == 0) begin
                    m_state = 0;
                    m_tries = MAX_TRIES;
                end
            end
            1: begin
                if (rl) m_state = 0;
                else if (pg && PROG_BUILD) begin
                    m_state = 4;
                    m_seq.delete();
                end
            end
            4: begin
                if (rl) begin
                    m_state = 1;
                    m_seq.delete();
                end else if (en) begin
                    m_seq.push_back(int'(d));
                    if (m_seq.size() == CODE_LEN) begin
                        m_code = pack_seq();
                        m_seq.delete();
                        m_state = 1;
                    end
                end
            end
            default: begin
                if (rl) begin
                    m_state = 0;
                    m_seq.delete();
                end else if (en) begin
                    m_state = 0;
                    m_seq.push_back(int'(d));
                    if (m_seq.size() == CODE_LEN) begin
                        if (pack_seq() == m_code) begin
                            m_state = 1;
                            m_tries = MAX_TRIES;
                        end else begin
                            m_tries--;
                            m_state = (m_tries == 0) ? 3 : 2;
                            m_lock_left = LOCKOUT_CYCLES;
                        end
                        m_seq.delete();
                    end
                end
            end
        endcase
    endtask

    task automatic drive(input logic en, input logic [3:0] d, input logic rl, input logic pg);
        bus.enter  = en;
        bus.digit  = d;
        bus.relock = rl;
`ifdef COMBO_LOCK_PROG_EN
        bus.prog   = pg;
`endif
    endtask

    task automatic step(input logic en, input logic [3:0] d, input logic rl, input logic pg);
        @(negedge clk);
        drive(en, d, rl, pg);
        @(posedge clk);
        model_edge(en, d, rl, pg);
        #1;
        drive(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < CODE_LEN; i++) step(1'b1, c[(CODE_LEN-1-i)*4 +: 4], 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        model_reset();
        #2;
        n_checks++; got = dut_outs(); want = model_outs();
        if (got !== want) $display("FAIL reset_outs: got %h expected %h", got, want); else n_pass++;
        n_checks++;
        if (bus.tries_left !== 2'd3 || bus.state !== 3'd0)
            $display("FAIL reset_const: got state %0d tries %0d expected 0 3", bus.state, bus.tries_left);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_open();
        logic [3:0] ds [4];
        ds = '{4'd1, 4'd2, 4'd3, 4'd4};
        do_reset();
        foreach (ds[i]) begin
            step(1'b1, ds[i], 1'b0, 1'b0);
            n_checks++; got = dut_outs(); want = model_outs();
            if (got !== want) $display("FAIL open_digit%0d: got %h expected %h", i, got, want); else n_pass++;
        end
        n_checks++;
        if (bus.open !== 1'b1 || bus.state !== 3'd1)
            $display("FAIL open_const: got open %b state %0d expected 1 1", bus.open, bus.state);
        else n_pass++;
        step(1'b1, 4'd7, 1'b0, 1'b0);
        n_checks++;
        if (bus.open !== 1'b1 || bus.digit_count !== 3'd0)
            $display("FAIL open_ignores_enter: got open %b count %0d expected 1 0", bus.open, bus.digit_count);
        else n_pass++;
        step(1'b0, 4'd0, 1'b1, 1'b0);
        n_checks++;
        if (bus.open !== 1'b0 || bus.state !== 3'd0)
            $display("FAIL relock_open: got open %b state %0d expected 0 0", bus.open, bus.state);
        else n_pass++;
    endtask

    task automatic test_fail();
        do_reset();
        enter_code(16'h1235);
        n_checks++;
        if (bus.fail !== 1'b1 || bus.tries_left !== 2'd2 || bus.digit_count !== 3'd0)
            $display("FAIL fail_const: got fail %b tries %0d count %0d expected 1 2 0",
                     bus.fail, bus.tries_left, bus.digit_count);
        else n_pass++;
        step(1'b1, 4'd1, 1'b0, 1'b0);
        n_checks++;
        if (bus.state !== 3'd0 || bus.digit_count !== 3'd1)
            $display("FAIL fail_restart: got state %0d count %0d expected 0 1", bus.state, bus.digit_count);
        else n_pass++;
        step(1'b1, 4'd2, 1'b0, 1'b0);
        step(1'b1, 4'd3, 1'b0, 1'b0);
        step(1'b1, 4'd4, 1'b0, 1'b0);
        n_checks++; got = dut_outs(); want = model_outs();
        if (got !== want) $display("FAIL fail_then_open: got %h expected %h", got, want); else n_pass++;
    endtask

    task automatic test_lockout();
        do_reset();
        for (int a = 0; a < MAX_TRIES; a++) begin
            enter_code({12'h123, 4'($urandom_range(5, 15))});
            n_checks++; got = dut_outs(); want = model_outs();
            if (got !== want) $display("FAIL lockout_attempt%0d: got %h expected %h", a, got, want); else n_pass++;
        end
        n_checks++;
        if (bus.locked_out !== 1'b1 || bus.state !== 3'd3)
            $display("FAIL lockout_entry: got locked_out %b state %0d expected 1 3", bus.locked_out, bus.state);
        else n_pass++;
        for (int c = 0; c < LOCKOUT_CYCLES; c++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            n_checks++; got = dut_outs(); want = model_outs();
            if (got !== want) $display("FAIL lockout_cycle%0d: got %h expected %h", c, got, want); else n_pass++;
        end
        n_checks++;
        if (bus.state !== 3'd0 || bus.tries_left !== 2'd3 || bus.locked_out !== 1'b0)
            $display("FAIL lockout_exit: got state %0d tries %0d lo %b expected 0 3 0",
                     bus.state, bus.tries_left, bus.locked_out);
        else n_pass++;
    endtask

    task automatic test_relock();
        do_reset();
        step(1'b1, 4'd1, 1'b0, 1'b0);
        step(1'b1, 4'd9, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        n_checks++;
        if (bus.digit_count !== 3'd0 || bus.tries_left !== 2'd3)
            $display("FAIL relock_partial: got count %0d tries %0d expected 0 3", bus.digit_count, bus.tries_left);
        else n_pass++;
        step(1'b1, 4'd1, 1'b1, 1'b0);
        n_checks++;
        if (bus.digit_count !== 3'd0)
            $display("FAIL enter_relock_same: got count %0d expected 0", bus.digit_count);
        else n_pass++;
        enter_code(CODE);
        n_checks++;
        if (bus.open !== 1'b1)
            $display("FAIL relock_clears_flag: got open %b expected 1", bus.open);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, 4'd1, 1'b0, 1'b0);
        step(1'b1, 4'd2, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; got = dut_outs(); want = model_outs();
        if (got !== want) $display("FAIL async_reset_attempt: got %h expected %h", got, want); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < MAX_TRIES; a++) enter_code(16'h9999);
        step(1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; got = dut_outs(); want = model_outs();
        if (got !== want) $display("FAIL async_reset_lockout: got %h expected %h", got, want); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef COMBO_LOCK_PROG_EN
    task automatic test_prog();
        do_reset();
        enter_code(CODE);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        n_checks++;
        if (bus.state !== 3'd4) $display("FAIL prog_enter: got state %0d expected 4", bus.state); else n_pass++;
        enter_code(16'h9876);
        n_checks++;
        if (bus.state !== 3'd1) $display("FAIL prog_done: got state %0d expected 1", bus.state); else n_pass++;
        step(1'b0, 4'd0, 1'b0, 1'b1);
        step(1'b1, 4'd5, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        n_checks++;
        if (bus.state !== 3'd1) $display("FAIL prog_abort: got state %0d expected 1", bus.state); else n_pass++;
        step(1'b0, 4'd0, 1'b1, 1'b0);
        enter_code(16'h1234);
        n_checks++;
        if (bus.fail !== 1'b1) $display("FAIL prog_old_code: got fail %b expected 1", bus.fail); else n_pass++;
        enter_code(16'h9876);
        n_checks++;
        if (bus.open !== 1'b1) $display("FAIL prog_new_code: got open %b expected 1", bus.open); else n_pass++;
    endtask
`endif

    task automatic test_random();
        int pos;
        logic [3:0] d;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            pos = (m_state == 2) ? 0 : m_seq.size();
            if (pos >= CODE_LEN) pos = 0;
            if (m_state != 4 && $urandom_range(0, 3) != 0) d = 4'(want_digit(pos));
            else d = 4'($urandom);
            step(1'($urandom_range(0, 2) != 0), d, 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 5) == 0));
            n_checks++; got = dut_outs(); want = model_outs();
            if (got !== want) $display("FAIL random_c%0d: got %h expected %h", c, got, want); else n_pass++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        model_reset();
        test_reset();
        test_open();
        test_fail();
        test_lockout();
        test_relock();
        test_async_reset();
`ifdef COMBO_LOCK_PROG_EN
        test_prog();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
